// File: rtl/sync_ram_dp_if.sv
// sync_ram_dp_if: bus bundle for the sync_ram_dp buffer.
//   clr_req / clr_busy / clr_done : clear engine request and status
//   wr_en / wr_addr / wr_be / wr_data : write port with per-byte enables
//   rd_en / rd_addr / rd_data / rd_valid : read port with a valid strobe
//   rd_perr : per-byte parity error, present only with SYNC_RAM_PARITY_EN
// master = requester side, slave = RAM side.
interface sync_ram_dp_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  localparam int unsigned NBYTE = DATA_W / 8;

  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [NBYTE-1:0]  wr_be;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
`ifdef SYNC_RAM_PARITY_EN
  logic [NBYTE-1:0]  rd_perr;

  modport master (
    output clr_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  clr_busy, clr_done, rd_data, rd_valid, rd_perr
  );
  modport slave (
    input  clr_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output clr_busy, clr_done, rd_data, rd_valid, rd_perr
  );
`else
  modport master (
    output clr_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  clr_busy, clr_done, rd_data, rd_valid
  );
  modport slave (
    input  clr_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output clr_busy, clr_done, rd_data, rd_valid
  );
`endif
endinterface

// File: rtl/sync_ram_dp.sv
// sync_ram_dp: parametrised simple-dual-port synchronous RAM with byte-enable
// writes, 1- or 2-cycle read latency with valid strobe, selectable
// read-during-write policy and a hardware clear engine.
// Ports: clk, rst_n (async active-low), bus (sync_ram_dp_if.slave).
// Optional macro SYNC_RAM_PARITY_EN adds per-byte even parity and rd_perr.
module sync_ram_dp #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned RDW_MODE = 0
) (
  input logic          clk,
  input logic          rst_n,
  sync_ram_dp_if.slave bus
);
  localparam int unsigned NBYTE = DATA_W / 8;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  // Storage array; deliberately not reset.
  logic [DATA_W-1:0] mem [DEPTH];
`ifdef SYNC_RAM_PARITY_EN
  logic [NBYTE-1:0]  par_mem [DEPTH];
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_busy_q, clr_busy_d;
  logic              clr_done_q, clr_done_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
`ifdef SYNC_RAM_PARITY_EN
  logic [NBYTE-1:0]  s1_perr_q, s1_perr_d;
  logic [NBYTE-1:0]  s2_perr_q, s2_perr_d;
  logic [NBYTE-1:0]  old_par;
  logic [NBYTE-1:0]  rd_perr_c;
`endif

  logic              wr_fire;
  logic              rd_fire;
  logic              rd_in_range;
  logic              collide;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] rd_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NBYTE-1:0]  mem_wbe;

  // Port acceptance: requests only honoured in IDLE and within DEPTH.
  always_comb begin
    wr_fire     = (state_q == ST_IDLE) && bus.wr_en && (32'(bus.wr_addr) < DEPTH);
    rd_fire     = (state_q == ST_IDLE) && bus.rd_en;
    rd_in_range = 32'(bus.rd_addr) < DEPTH;
    collide     = wr_fire && (bus.wr_addr == bus.rd_addr);
  end

  // Read word at issue; write-first merges enabled bytes of a colliding write.
  always_comb begin
    old_word = rd_in_range ? mem[bus.rd_addr] : '0;
    rd_word  = old_word;
    for (int unsigned i = 0; i < NBYTE; i++) begin
      if ((RDW_MODE == 1) && collide && bus.wr_be[i]) begin
        rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
    end
  end

`ifdef SYNC_RAM_PARITY_EN
  // Per-byte parity check of the word returned at issue.
  always_comb begin
    old_par   = rd_in_range ? par_mem[bus.rd_addr] : '0;
    rd_perr_c = '0;
    for (int unsigned i = 0; i < NBYTE; i++) begin
      if ((RDW_MODE == 1) && collide && bus.wr_be[i]) begin
        rd_perr_c[i] = (^rd_word[8*i +: 8]) ^ (^bus.wr_data[8*i +: 8]);
      end else begin
        rd_perr_c[i] = (^rd_word[8*i +: 8]) ^ old_par[i];
      end
    end
  end
`endif

  // Clear FSM, memory write port mux and read pipeline next-state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_busy_d = clr_busy_q;
    clr_done_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = bus.wr_addr;
    mem_wdata  = bus.wr_data;
    mem_wbe    = bus.wr_be;

    case (state_q)
      ST_IDLE: begin
        mem_we = wr_fire;
        if (bus.clr_req) begin
          state_d    = ST_CLEAR;
          cnt_d      = '0;
          clr_busy_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        mem_wbe   = '1;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          clr_busy_d = 1'b0;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Data registers hold their last value when no read completes.
    s1_valid_d = rd_fire;
    s1_data_d  = rd_fire ? rd_word : s1_data_q;
    s2_valid_d = s1_valid_q;
    s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
`ifdef SYNC_RAM_PARITY_EN
    s1_perr_d  = rd_fire ? rd_perr_c : '0;
    s2_perr_d  = s1_valid_q ? s1_perr_q : '0;
`endif
  end

  // Control and read-pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_data_q  <= '0;
`ifdef SYNC_RAM_PARITY_EN
      s1_perr_q  <= '0;
      s2_perr_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_data_q  <= s1_data_d;
      s2_data_q  <= s2_data_d;
`ifdef SYNC_RAM_PARITY_EN
      s1_perr_q  <= s1_perr_d;
      s2_perr_q  <= s2_perr_d;
`endif
    end
  end

  // Array write with byte enables.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NBYTE; i++) begin
        if (mem_wbe[i]) begin
          mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
`ifdef SYNC_RAM_PARITY_EN
          par_mem[mem_waddr][i]    <= ^mem_wdata[8*i +: 8];
`endif
        end
      end
    end
  end

  assign bus.clr_busy = clr_busy_q;
  assign bus.clr_done = clr_done_q;
  assign bus.rd_valid = (RD_LAT == 2) ? s2_valid_q : s1_valid_q;
  assign bus.rd_data  = (RD_LAT == 2) ? s2_data_q  : s1_data_q;
`ifdef SYNC_RAM_PARITY_EN
  assign bus.rd_perr  = (RD_LAT == 2) ? s2_perr_q  : s1_perr_q;
`endif
endmodule
